// File: rtl/if_fetch_ctrl_pkg.sv
// if_fetch_ctrl_pkg: shared pipeline types and constants for the fetch stage
package if_fetch_ctrl_pkg;
  typedef enum logic [1:0] {FETCH, HOLD, DRAIN, HALTED} fetch_state_e;
  localparam logic [15:0] RESET_PC_DEF = 16'h0000;
  localparam logic [15:0] NOP = 16'h0000;
endpackage

// File: rtl/if_fetch_ctrl_cla16.sv
// cla16: 16-bit adder, ripple inside 4-bit groups with lookahead between groups
module cla16 (
  input  logic [15:0] a,
  input  logic [15:0] b,
  input  logic        cin,
  output logic [15:0] sum
);
  logic [14:0] g;
  logic [15:0] p, c;
  assign g = a[14:0] & b[14:0];
  assign p = a ^ b;
  assign c[0] = cin;
  for (genvar k = 0; k < 4; k++) begin : grp
    for (genvar j = 0; j < 3; j++) begin : bitc
      assign c[4*k+j+1] = g[4*k+j] | (p[4*k+j] & c[4*k+j]);
    end
    if (k < 3) begin : look
      logic gg, gp;
      assign gp = &p[4*k+:4];
      assign gg = g[4*k+3] | (p[4*k+3] & g[4*k+2]) | (p[4*k+3] & p[4*k+2] & g[4*k+1])
                | (p[4*k+3] & p[4*k+2] & p[4*k+1] & g[4*k]);
      assign c[4*k+4] = gg | (gp & c[4*k]);
    end
  end
  assign sum = p ^ c;
endmodule

// File: rtl/if_fetch_ctrl.sv
// if_fetch_ctrl: instruction fetch control with I-cache handshake, stall buffer, redirect drain and halt
module if_fetch_ctrl
  import if_fetch_ctrl_pkg::*;
#(
  parameter logic [15:0] RESET_PC = RESET_PC_DEF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        redirect,
  input  logic [15:0] redirect_pc,
  input  logic        stall,
  input  logic        halt,
  output logic        mem_rd,
  output logic [15:0] mem_addr,
  input  logic        mem_done,
  input  logic [15:0] mem_data,
  output logic [15:0] if_instr,
  output logic [15:0] if_pc,
  output logic [15:0] if_pc_2,
  output logic        if_valid,
  output logic        fetch_busy,
  output logic        halted
);
  fetch_state_e state;
  logic [15:0] pc_q, req_addr, buf_q, pc_2;
  logic halt_pend;
  cla16 u_inc (.a(req_addr), .b(16'd2), .cin(1'b0), .sum(pc_2));
  assign mem_rd = (state == FETCH) || (state == DRAIN);
  assign mem_addr = req_addr;
  assign fetch_busy = mem_rd & ~mem_done;
  assign halted = state == HALTED;
  // halt_pend keeps a halt sticky while its outstanding request drains
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state <= FETCH;
      pc_q <= RESET_PC;
      req_addr <= RESET_PC;
      buf_q <= NOP;
      halt_pend <= 1'b0;
      if_instr <= NOP;
      if_pc <= 16'h0000;
      if_pc_2 <= 16'h0000;
      if_valid <= 1'b0;
    end else if (state != HALTED) begin
      if (halt || halt_pend) begin
        if_valid <= 1'b0;
        buf_q <= NOP;
        halt_pend <= fetch_busy;
        state <= fetch_busy ? DRAIN : HALTED;
      end else if (redirect) begin
        if_valid <= 1'b0;
        buf_q <= NOP;
        pc_q <= redirect_pc;
        if (fetch_busy) state <= DRAIN;
        else begin
          req_addr <= redirect_pc;
          state <= FETCH;
        end
      end else if (state == DRAIN) begin
        if (!stall) if_valid <= 1'b0;
        if (mem_done) begin
          req_addr <= pc_q;
          state <= FETCH;
        end
      end else if (!stall && (state == HOLD || mem_done)) begin
        if_instr <= (state == HOLD) ? buf_q : mem_data;
        if_pc <= req_addr;
        if_pc_2 <= pc_2;
        if_valid <= 1'b1;
        pc_q <= pc_2;
        req_addr <= pc_2;
        state <= FETCH;
      end else if (state == FETCH && mem_done) begin
        buf_q <= mem_data;
        state <= HOLD;
      end else if (!stall) if_valid <= 1'b0;
    end
endmodule

// File: tb/tb_if_fetch_ctrl.sv
// tb_if_fetch_ctrl: directed and randomized checks of if_fetch_ctrl against a behavioural fetch model
module tb_if_fetch_ctrl;
  logic clk = 1'b0, rst = 1'b1, redirect = 1'b0, stall = 1'b0, halt = 1'b0, mem_done = 1'b0;
  logic [15:0] redirect_pc = 16'h0000, mem_data = 16'h0000;
  logic mem_rd, fetch_busy, if_valid, halted;
  logic [15:0] mem_addr, if_instr, if_pc, if_pc_2;
  int errs = 0, checks = 0;
  bit run = 1'b0;
  logic [15:0] m_pc, m_addr, m_instr, m_ipc, m_ipc2;
  bit m_valid, m_drain, m_hp, m_halted;
  logic [15:0] held[$];

  if_fetch_ctrl dut (
    .clk(clk), .rst(rst), .redirect(redirect), .redirect_pc(redirect_pc), .stall(stall), .halt(halt),
    .mem_rd(mem_rd), .mem_addr(mem_addr), .mem_done(mem_done), .mem_data(mem_data),
    .if_instr(if_instr), .if_pc(if_pc), .if_pc_2(if_pc_2), .if_valid(if_valid),
    .fetch_busy(fetch_busy), .halted(halted)
  );

  always #5 clk = ~clk;

  task automatic chk(string n, logic [15:0] got, logic [15:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %h expected %h at %0t", n, got, exp, $time);
    end
  endtask

  task automatic mreset();
    m_pc = 16'h0000; m_addr = 16'h0000; m_instr = 16'h0000; m_ipc = 16'h0000; m_ipc2 = 16'h0000;
    m_valid = 0; m_drain = 0; m_hp = 0; m_halted = 0;
    held.delete();
  endtask

  task automatic load(logic [15:0] w);
    m_instr = w; m_ipc = m_addr; m_ipc2 = m_addr + 16'd2; m_valid = 1;
    m_addr = m_addr + 16'd2; m_pc = m_addr;
  endtask

  function automatic bit exp_rd();
    return !m_halted && held.size() == 0;
  endfunction

  task automatic cmp();
    chk("mem_rd", mem_rd, exp_rd());
    if (exp_rd()) chk("mem_addr", mem_addr, m_addr);
    chk("fetch_busy", fetch_busy, exp_rd() && !mem_done);
    chk("halted", halted, m_halted);
    chk("if_valid", if_valid, m_valid);
    chk("if_instr", if_instr, m_instr);
    chk("if_pc", if_pc, m_ipc);
    chk("if_pc_2", if_pc_2, m_ipc2);
  endtask

  // what the stage must do with this cycle's inputs, applied at the coming edge
  task automatic mstep();
    bit erd;
    logic [15:0] w;
    erd = exp_rd();
    if (!m_halted) begin
      if (halt || m_hp) begin
        m_valid = 0; held.delete();
        m_hp = erd && !mem_done; m_drain = m_hp; m_halted = !m_hp;
      end else if (redirect) begin
        m_valid = 0; held.delete(); m_pc = redirect_pc;
        if (erd && !mem_done) m_drain = 1;
        else begin m_drain = 0; m_addr = redirect_pc; end
      end else if (m_drain) begin
        if (!stall) m_valid = 0;
        if (mem_done) begin m_drain = 0; m_addr = m_pc; end
      end else if (held.size() > 0) begin
        if (!stall) begin w = held.pop_front(); load(w); end
      end else if (mem_done && !stall) load(mem_data);
      else if (mem_done) held.push_back(mem_data);
      else if (!stall) m_valid = 0;
    end
  endtask

  always @(negedge clk) if (run) begin cmp(); mstep(); end

  task automatic drive(bit s, bit r, bit h, logic [15:0] p, bit d, logic [15:0] w);
    @(posedge clk); #2;
    stall = s; redirect = r; halt = h; redirect_pc = p; mem_done = d; mem_data = w;
    #1;
  endtask

  task automatic do_reset();
    run = 0;
    @(posedge clk); #2;
    rst = 1; stall = 0; redirect = 0; halt = 0; mem_done = 0;
    #1;
    chk("rst_valid", if_valid, 0);
    chk("rst_instr", if_instr, 16'h0000);
    chk("rst_pc", if_pc, 16'h0000);
    chk("rst_halted", halted, 0);
    chk("rst_addr", mem_addr, 16'h0000);
    mreset();
    @(posedge clk); #2;
    rst = 0; run = 1;
  endtask

  initial begin
    do_reset();
    // back-to-back hits from reset
    drive(0, 0, 0, 0, 1, 16'h1111); chk("first_rd", mem_rd, 1); chk("hit_a0", mem_addr, 16'h0000);
    drive(0, 0, 0, 0, 1, 16'h2222); chk("hit_p0", if_pc, 16'h0000); chk("hit_i0", if_instr, 16'h1111);
    chk("hit_a2", mem_addr, 16'h0002);
    drive(0, 0, 0, 0, 1, 16'h3333); chk("hit_p2", if_pc, 16'h0002); chk("hit_p2_2", if_pc_2, 16'h0004);
    drive(0, 0, 0, 0, 0, 0); chk("hit_p4", if_pc, 16'h0004); chk("hit_v4", if_valid, 1);
    chk("hit_i4", if_instr, 16'h3333);
    // miss with three wait cycles
    drive(0, 1, 0, 16'h0010, 1, 16'hDEAD);
    for (int i = 0; i < 3; i++) begin
      drive(0, 0, 0, 0, 0, 0); chk("miss_addr", mem_addr, 16'h0010); chk("miss_busy", fetch_busy, 1);
    end
    drive(0, 0, 0, 0, 1, 16'hBEEF); chk("miss_addr_done", mem_addr, 16'h0010); chk("miss_busy_done", fetch_busy, 0);
    drive(0, 0, 0, 0, 0, 0); chk("miss_valid", if_valid, 1); chk("miss_pc", if_pc, 16'h0010);
    chk("miss_instr", if_instr, 16'hBEEF);
    drive(0, 0, 0, 0, 0, 0); chk("miss_once", if_valid, 0);
    // stall in the delivery cycle
    drive(0, 1, 0, 16'h0020, 1, 0);
    drive(1, 0, 0, 0, 1, 16'hA5A5); chk("stall_addr", mem_addr, 16'h0020);
    drive(1, 0, 0, 0, 0, 0); chk("hold_rd", mem_rd, 0); chk("hold_valid", if_valid, 0);
    drive(0, 0, 0, 0, 0, 0); chk("hold_rd2", mem_rd, 0);
    drive(0, 1, 0, 16'h0040, 1, 0); chk("rel_instr", if_instr, 16'hA5A5); chk("rel_pc", if_pc, 16'h0020);
    chk("rel_valid", if_valid, 1); chk("rel_next", mem_addr, 16'h0022);
    // redirect while a miss is outstanding
    drive(0, 0, 0, 0, 0, 0); chk("rd_miss_addr", mem_addr, 16'h0040);
    drive(0, 1, 0, 16'h0100, 0, 0); chk("rd_cycle_addr", mem_addr, 16'h0040);
    drive(0, 0, 0, 0, 0, 0); chk("drain_addr", mem_addr, 16'h0040); chk("drain_valid", if_valid, 0);
    drive(0, 0, 0, 0, 1, 16'h4444); chk("drain_done_addr", mem_addr, 16'h0040);
    drive(0, 0, 0, 0, 0, 0); chk("drain_discard", if_valid, 0); chk("drain_target", mem_addr, 16'h0100);
    chk("drain_instr", if_instr, 16'hA5A5);
    // wrap at the top of the address space
    drive(0, 1, 0, 16'hFFFE, 1, 0);
    drive(0, 0, 0, 0, 1, 16'h7777); chk("wrap_addr", mem_addr, 16'hFFFE);
    drive(0, 0, 0, 0, 0, 0); chk("wrap_pc", if_pc, 16'hFFFE); chk("wrap_pc_2", if_pc_2, 16'h0000);
    chk("wrap_next", mem_addr, 16'h0000);
    // halt together with redirect, request outstanding
    drive(0, 1, 1, 16'h0300, 0, 0);
    drive(0, 0, 0, 0, 0, 0); chk("halt_drain", halted, 0); chk("halt_drain_rd", mem_rd, 1);
    chk("halt_drain_addr", mem_addr, 16'h0000);
    drive(0, 0, 0, 0, 1, 16'h9999); chk("halt_drain_addr2", mem_addr, 16'h0000);
    drive(0, 0, 0, 0, 0, 0); chk("halted", halted, 1); chk("halted_rd", mem_rd, 0);
    chk("halted_instr", if_instr, 16'h7777);
    for (int i = 0; i < 4; i++) begin
      drive(0, 1, 0, 16'h0400, 1, 0); chk("halted_stay", mem_rd, 0); chk("halted_valid", if_valid, 0);
    end
    // reset in the middle of a miss
    do_reset();
    drive(0, 0, 0, 0, 0, 0);
    drive(0, 0, 0, 0, 0, 0);
    do_reset();
    drive(0, 0, 0, 0, 1, 16'h5555); chk("post_rst_addr", mem_addr, 16'h0000);
    drive(0, 0, 0, 0, 0, 0); chk("post_rst_instr", if_instr, 16'h5555);
    // randomized traffic
    for (int b = 0; b < 5; b++) begin
      do_reset();
      for (int i = 0; i < 400; i++) begin
        @(posedge clk); #2;
        stall = ($urandom % 10) < 3;
        redirect = ($urandom % 10) == 0;
        halt = ($urandom % 300) == 0;
        redirect_pc = ($urandom % 4 == 0) ? (16'hFFFC | 16'($urandom % 4)) : 16'($urandom);
        mem_data = 16'($urandom);
        mem_done = mem_rd && ($urandom % 2 == 1);
      end
    end
    @(posedge clk); #2;
    run = 0;
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
